oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine: a CPU-visible register at 0xFF46 which, when written, copies 160 bytes from `{value, 8'h00}` to sprite attribute memory (0xFE00–0xFE9F). On the shared data bus it acts as the initiator; the graphics peripheral, which owns OAM, is the responder. It requests bus ownership from the arbiter, performs the read and write cycles itself, then releases the bus.

## Interface
- `READ_LATENCY`, default 1: cycles from a read strobe until `m_rdata` is valid. Range 1–4.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reg_addr`  in  16  CPU-side address.
- `reg_rd`  in  1  CPU read strobe.
- `reg_wr`  in  1  CPU write strobe.
- `reg_wdata`  in  8  CPU write data.
- `reg_rdata`  out  8  register readback; valid the cycle after `reg_rd`.
- `reg_hit`  out  1  registered; high the cycle after a `reg_rd` that decodes to 0xFF46.
- `bus_req`  out  1  bus ownership request.
- `bus_gnt`  in  1  arbiter grant.
- `m_addr`  out  16  initiator address.
- `m_rd`  out  1  initiator read strobe.
- `m_wr`  out  1  initiator write strobe.
- `m_wdata`  out  8  initiator write data.
- `m_rdata`  in  8  responder read data.
- `busy`  out  1  a transfer is in progress.
- `dma_done`  out  1  one-cycle pulse when a transfer completes (present only when the Configuration macro is defined).

## Operation
- **Register.** `reg_wr` to 0xFF46 stores `reg_wdata` in `src_hi` and starts a transfer. `reg_rd` returns `src_hi`. Any other address leaves the block unaffected.
- **FSM states:** IDLE, REQ, READ, WAIT, WRITE, RELEASE.
- **IDLE.** Enter REQ on a register write, with `idx=0`.
- **REQ.** Hold `bus_req=1`. When `bus_gnt=1`, go to READ.
- **READ.** Drive `m_addr = {src_hi,8'h00}+idx` and `m_rd=1` for one cycle, then go to WAIT.
- **WAIT.** Stay `READ_LATENCY` cycles. On the last of those cycles, latch `m_rdata` into `data_q`, then go to WRITE.
- **WRITE.** Drive `m_addr = 16'hFE00+idx`, `m_wdata=data_q`, `m_wr=1` for one cycle.
  - If `idx==159`, go to RELEASE.
  - Otherwise increment `idx` and go to READ.
- **RELEASE.** Drop `bus_req` and `busy`, then go to IDLE.
- **Strobe gating.**
  - `m_rd = (state==READ) & bus_gnt`.
  - `m_wr = (state==WRITE) & bus_gnt`.
  - `m_addr` and `m_wdata` are 0 outside READ and WRITE.
- **Index and address width.**
  - `idx` is 8 bits.
  - Address arithmetic is 16-bit; the maximum source address is 0xFF9F, so no wrap is possible.
- **Grant loss.** If `bus_gnt=0` in READ, WAIT or WRITE, return to REQ with `idx` unchanged. Any partially read byte is discarded and re-read from READ.
- **Restart.** A register write while busy loads the new `src_hi`, sets `idx=0` and returns to REQ.
  - A strobe already driven in that cycle still occurs.
  - No completion is signalled for the aborted transfer.
- **Simultaneous events.** A register write in the final WRITE cycle is treated as a restart; RELEASE is not entered.
- **Reset.** Asynchronous, applies at any time, mid-transfer included. Every output goes to 0, `src_hi=0`, `idx=0`, state=IDLE.

## Timing
- Register write at cycle t: `busy` and `bus_req` go high at t+1.
- With the grant held high, each byte takes `2+READ_LATENCY` cycles; the default gives 3 cycles per byte, 480 cycles per transfer.
- `busy` falls in the cycle after the last `m_wr`.
- `reg_rdata` and `reg_hit` are registered (1-cycle latency). They are 0 in every cycle that did not follow a decoded read.
- `bus_req` is never dropped before RELEASE, except on reset.

## Configuration
- Macro: `OAM_DMA_DONE_PULSE_EN`.
- **Defined:** the `dma_done` port exists. It pulses high for exactly one cycle, in the RELEASE cycle, once per completed (non-aborted) transfer.
- **Undefined:** the port and its logic are absent. Completion is observable only through the fall of `busy`.

## Structure
- The shared package `video_types` holds:
  - constants `DMA_REG_ADDR=16'hFF46`, `OAM_DMA_BASE=16'hFE00`, `OAM_DMA_LEN=160`;
  - the enum `dma_state_t`.
- One sub-module: `oam_dma_reg`, the CPU register slice. It handles decode, `src_hi` storage, the registered `reg_rdata`/`reg_hit`, and emits a one-cycle `start` pulse to the FSM.

## Test plan
- **Basic copy.** Model memory C100–C19F = `i^8'h5A`; grant after 2 cycles; write 0xC1 to 0xFF46 → OAM FE00–FE9F match the model, 160 `m_wr`, `busy` high for 483 cycles, a single `dma_done`.
- **Readback.** Write 0x80 to 0xFF46, then read it → `reg_rdata=0x80`, `reg_hit=1` on the next cycle. Read 0xFF47 → `reg_hit=0`, `reg_rdata=0`.
- **Restart.** Start from 0xC0; after 30 writes, write 0xD0 → the transfer restarts at `idx` 0 from D000; final OAM is entirely D0xx data; exactly one `dma_done`.
- **Grant loss.** Drop `bus_gnt` for 5 cycles during WAIT of byte 50 → no `m_rd`/`m_wr` while low; byte 50 is re-read from C132 (source 0xC1); OAM is correct at the end.
- **Reset mid-transfer.** Assert `reset_n=0` at byte 100 → all outputs 0 in the same cycle, no further bus strobes, readback returns 0x00.
- **Latency.** With `READ_LATENCY=3` → 5 cycles per byte, 800 cycles of transfer; data is latched exactly 3 cycles after `m_rd`.

Source files
------------

// File: rtl/video_types.sv
// video_types: shared constants and FSM state type for the OAM DMA engine
//   DMA_REG_ADDR : CPU address of the DMA source register
//   OAM_DMA_BASE : first OAM byte written by a transfer
//   OAM_DMA_LEN  : bytes copied per transfer
//   dma_state_t  : transfer FSM states
package video_types;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_DMA_BASE = 16'hFE00;
  localparam int OAM_DMA_LEN = 160;
  typedef enum logic [2:0] {IDLE, REQ, READ, WAIT, WRITE, RELEASE} dma_state_t;
endpackage

// File: rtl/oam_dma_reg.sv
// oam_dma_reg: CPU register slice for the OAM DMA source page
//   clk, reset_n            : clock, asynchronous active-low reset
//   reg_addr/rd/wr/wdata    : CPU access
//   reg_rdata, reg_hit      : registered readback, zero unless the previous cycle read 0xFF46
//   src_hi                  : stored source page
//   start                   : one-cycle pulse on a decoded write
module oam_dma_reg
  import video_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] reg_addr,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic [7:0]  src_hi,
  output logic        start
);
  logic hit;
  assign hit = reg_addr == DMA_REG_ADDR;
  assign start = reg_wr & hit;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      src_hi <= '0;
      reg_rdata <= '0;
      reg_hit <= 1'b0;
    end else begin
      if (start) src_hi <= reg_wdata;
      reg_hit <= reg_rd & hit;
      reg_rdata <= (reg_rd & hit) ? src_hi : '0;
    end
endmodule

// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine copying 160 bytes from {src_hi,8'h00} to OAM 0xFE00-0xFE9F over a shared bus
//   clk, reset_n                   : clock, asynchronous active-low reset
//   reg_addr/rd/wr/wdata           : CPU access to the 0xFF46 source register
//   reg_rdata, reg_hit             : registered register readback
//   bus_req, bus_gnt               : bus ownership handshake with the arbiter
//   m_addr/rd/wr/wdata, m_rdata    : initiator side of the shared bus
//   busy                           : transfer in progress
//   dma_done                       : completion pulse, only with OAM_DMA_DONE_PULSE_EN defined
module oam_dma
  import video_types::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] reg_addr,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_hit,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
`ifdef OAM_DMA_DONE_PULSE_EN
  output logic        dma_done,
`endif
  output logic        busy
);
  dma_state_t state, nxt;
  logic [7:0] src_hi, idx, data_q;
  logic [1:0] wcnt;
  logic start, last, wdone, active;
  oam_dma_reg u_reg (
    .clk(clk),
    .reset_n(reset_n),
    .reg_addr(reg_addr),
    .reg_rd(reg_rd),
    .reg_wr(reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .reg_hit(reg_hit),
    .src_hi(src_hi),
    .start(start)
  );
  assign last = idx == 8'(OAM_DMA_LEN - 1);
  assign wdone = wcnt == 2'(READ_LATENCY - 1);
  // a register write restarts from any state; losing the grant mid-byte re-requests the bus
  always_comb begin
    nxt = start ? REQ :
          (state inside {READ, WAIT, WRITE} && !bus_gnt) ? REQ :
          state == REQ   ? (bus_gnt ? READ : REQ) :
          state == READ  ? WAIT :
          state == WAIT  ? (wdone ? WRITE : WAIT) :
          state == WRITE ? (last ? RELEASE : READ) : IDLE;
  end
  assign active = nxt inside {REQ, READ, WAIT, WRITE};
  assign m_rd = (state == READ) & bus_gnt;
  assign m_wr = (state == WRITE) & bus_gnt;
  assign m_addr = state == READ  ? {src_hi, 8'h00} + {8'h00, idx} :
                  state == WRITE ? OAM_DMA_BASE + {8'h00, idx} : '0;
  assign m_wdata = state == WRITE ? data_q : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      wcnt <= '0;
      data_q <= '0;
      busy <= 1'b0;
      bus_req <= 1'b0;
`ifdef OAM_DMA_DONE_PULSE_EN
      dma_done <= 1'b0;
`endif
    end else begin
      state <= nxt;
      busy <= active;
      bus_req <= active;
      idx <= start ? '0 : (state == WRITE && nxt == READ) ? idx + 8'd1 : idx;
      wcnt <= (state == WAIT && nxt == WAIT) ? wcnt + 2'd1 : '0;
      if (state == WAIT && nxt == WRITE) data_q <= m_rdata;
`ifdef OAM_DMA_DONE_PULSE_EN
      dma_done <= nxt == RELEASE;
`endif
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma (default and READ_LATENCY=3 instances)
module tb_oam_dma;
  localparam int LAT = 1;
  localparam int LAT3 = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [15:0] reg_addr = '0;
  logic reg_rd = 1'b0, reg_wr = 1'b0;
  logic [7:0] reg_wdata = '0;
  logic [7:0] reg_rdata;
  logic reg_hit, bus_req, m_rd, m_wr, busy;
  logic bus_gnt = 1'b0;
  logic [15:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata = '0;
  logic [15:0] l_reg_addr = '0;
  logic l_reg_wr = 1'b0;
  logic [7:0] l_reg_wdata = '0;
  logic [7:0] l_reg_rdata;
  logic l_reg_hit, l_bus_req, l_m_rd, l_m_wr, l_busy;
  logic [15:0] l_m_addr;
  logic [7:0] l_m_wdata;
  logic [7:0] l_m_rdata = '0;
`ifdef OAM_DMA_DONE_PULSE_EN
  logic dma_done, l_dma_done;
`endif
  oam_dma #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_hit(reg_hit), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
    .m_rdata(m_rdata),
`ifdef OAM_DMA_DONE_PULSE_EN
    .dma_done(dma_done),
`endif
    .busy(busy)
  );
  oam_dma #(.READ_LATENCY(LAT3)) u_lat (
    .clk(clk), .reset_n(reset_n), .reg_addr(l_reg_addr), .reg_rd(1'b0), .reg_wr(l_reg_wr),
    .reg_wdata(l_reg_wdata), .reg_rdata(l_reg_rdata), .reg_hit(l_reg_hit), .bus_req(l_bus_req),
    .bus_gnt(1'b1), .m_addr(l_m_addr), .m_rd(l_m_rd), .m_wr(l_m_wr), .m_wdata(l_m_wdata),
    .m_rdata(l_m_rdata),
`ifdef OAM_DMA_DONE_PULSE_EN
    .dma_done(l_dma_done),
`endif
    .busy(l_busy)
  );
  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:159];
  int vec = 0, err = 0;
  logic [7:0] src = '0;
  int exp_idx = 0, wr_cnt = 0, busy_cyc = 0, done_cnt = 0, rd50_cnt = 0;
  int drop_cnt = 0, gcnt = 0;
  bit drop_arm = 0, rnd_drop = 0, expect_fall = 0;
  int l_idx = 0, l_wr_cnt = 0, l_busy_cyc = 0, l_done_cnt = 0, l_cyc = 0, l_rd_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // arbiter: grant once the request has been seen for 3 cycles, with optional forced drops
  initial forever begin
    @(posedge clk); #1;
    gcnt = (bus_req && reset_n) ? gcnt + 1 : 0;
    if (rnd_drop && drop_cnt == 0 && $urandom_range(0, 40) == 0) drop_cnt = $urandom_range(1, 6);
    if (drop_cnt > 0) begin
      bus_gnt = 1'b0;
      drop_cnt--;
    end else bus_gnt = reset_n && gcnt >= 3;
  end

  // responders: data valid only exactly LAT cycles after the read strobe, inverted otherwise
  logic pv [0:4] = '{default: 1'b0};
  logic [15:0] pa [0:4] = '{default: 16'h0};
  logic lv [0:4] = '{default: 1'b0};
  logic [15:0] la [0:4] = '{default: 16'h0};
  always @(negedge clk) begin
    for (int k = 4; k > 0; k--) begin
      pv[k] = pv[k-1]; pa[k] = pa[k-1];
      lv[k] = lv[k-1]; la[k] = la[k-1];
    end
    pv[0] = m_rd; pa[0] = m_addr;
    lv[0] = l_m_rd; la[0] = l_m_addr;
    m_rdata = pv[LAT] === 1'b1 ? mem[pa[LAT]] : ~mem[pa[LAT]];
    l_m_rdata = lv[LAT3] === 1'b1 ? mem[la[LAT3]] : ~mem[la[LAT3]];
  end

  always @(negedge clk) begin
    check("req_eq_busy", bus_req, busy);
    if (!bus_gnt) check("strobe_without_gnt", {m_rd, m_wr}, 0);
    if (expect_fall) begin
      check("busy_fall", busy, 0);
      expect_fall = 0;
    end
    if (busy) busy_cyc++;
`ifdef OAM_DMA_DONE_PULSE_EN
    if (dma_done) done_cnt++;
`endif
    if (m_rd) begin
      check("rd_addr", m_addr, {src, 8'h00} + exp_idx);
      if (exp_idx == 50) begin
        rd50_cnt++;
        if (drop_arm) begin
          drop_cnt = 5;
          drop_arm = 0;
        end
      end
    end
    if (m_wr) begin
      check("wr_addr", m_addr, 16'hFE00 + exp_idx);
      check("wr_data", m_wdata, mem[{src, 8'h00} + exp_idx]);
      if (m_addr >= 16'hFE00 && m_addr < 16'hFEA0) oam[m_addr - 16'hFE00] = m_wdata;
      if (exp_idx == 159) expect_fall = 1;
      exp_idx++;
      wr_cnt++;
    end
  end

  always @(negedge clk) begin
    l_cyc++;
    if (l_busy) l_busy_cyc++;
`ifdef OAM_DMA_DONE_PULSE_EN
    if (l_dma_done) l_done_cnt++;
`endif
    if (l_m_rd) l_rd_cyc = l_cyc;
    if (l_m_wr) begin
      check("lat_gap", l_cyc - l_rd_cyc, LAT3 + 1);
      check("lat_wr_addr", l_m_addr, 16'hFE00 + l_idx);
      check("lat_wr_data", l_m_wdata, mem[16'hC100 + l_idx]);
      l_idx++;
      l_wr_cnt++;
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; busy_cyc = 0; done_cnt = 0; rd50_cnt = 0;
    for (int i = 0; i < 160; i++) oam[i] = 'x;
  endtask

  task automatic dma_write(input logic [7:0] v);
    @(posedge clk); #1;
    reg_addr = 16'hFF46; reg_wdata = v; reg_wr = 1'b1;
    @(posedge clk); #1;
    reg_wr = 1'b0; reg_addr = '0;
    src = v; exp_idx = 0;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    logic hit;
    hit = a == 16'hFF46;
    @(posedge clk); #1;
    reg_addr = a; reg_rd = 1'b1;
    @(posedge clk); #1;
    reg_rd = 1'b0; reg_addr = '0;
    check("rd_hit", reg_hit, hit);
    check("rd_data", reg_rdata, hit ? src : 8'h00);
    @(posedge clk); #1;
    check("rd_hit_clear", reg_hit, 0);
    check("rd_data_clear", reg_rdata, 0);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wr_timeout", wr_cnt >= target, 1);
  endtask

  task automatic check_oam(input logic [7:0] s);
    for (int i = 0; i < 160; i++) check("oam", oam[i], mem[{s, 8'h00} + i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] s;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_strobes", {m_rd, m_wr}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_reg_out", {reg_hit, reg_rdata}, 0);
    @(negedge clk) reset_n = 1'b1;
    // readback
    clear_stats();
    dma_write(8'h80);
    check("busy_after_write", busy, 1);
    check("req_after_write", bus_req, 1);
    cpu_read(16'hFF46);
    cpu_read(16'hFF47);
    wait_idle(2000);
    check_oam(8'h80);
    // basic copy
    clear_stats();
    dma_write(8'hC1);
    wait_idle(2000);
    check("basic_busy_cycles", busy_cyc, 483);
    check("basic_wr_count", wr_cnt, 160);
`ifdef OAM_DMA_DONE_PULSE_EN
    check("basic_done_count", done_cnt, 1);
`endif
    check_oam(8'hC1);
    // restart
    clear_stats();
    dma_write(8'hC0);
    wait_wr(30);
    dma_write(8'hD0);
    wait_idle(2000);
    check("restart_writes", exp_idx, 160);
`ifdef OAM_DMA_DONE_PULSE_EN
    check("restart_done_count", done_cnt, 1);
`endif
    check_oam(8'hD0);
    // grant loss at byte 50
    clear_stats();
    drop_arm = 1;
    dma_write(8'hC1);
    wait_idle(2000);
    check("gloss_rd50_count", rd50_cnt, 2);
    check("gloss_wr_count", wr_cnt, 160);
    check("gloss_busy_cycles", busy_cyc, 490);
    check_oam(8'hC1);
    // randomized transfers with random grant drops and register reads
    for (int t = 0; t < 3; t++) begin
      clear_stats();
      s = 8'($urandom_range(0, 255));
      rnd_drop = 1;
      dma_write(s);
      for (int r = 0; r < 3; r++) begin
        a = $urandom_range(0, 1) ? 16'hFF46 : 16'($urandom);
        cpu_read(a);
        repeat ($urandom_range(1, 40)) @(posedge clk);
      end
      wait_idle(6000);
      rnd_drop = 0;
      drop_cnt = 0;
      check("rand_wr_count", wr_cnt, 160);
`ifdef OAM_DMA_DONE_PULSE_EN
      check("rand_done_count", done_cnt, 1);
`endif
      check_oam(s);
    end
    // reset mid-transfer
    clear_stats();
    dma_write(8'hC1);
    wait_wr(100);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mrst_busy_req", {busy, bus_req}, 0);
    check("mrst_strobes", {m_rd, m_wr}, 0);
    check("mrst_m_addr", m_addr, 0);
    check("mrst_m_wdata", m_wdata, 0);
    check("mrst_reg_out", {reg_hit, reg_rdata}, 0);
`ifdef OAM_DMA_DONE_PULSE_EN
    check("mrst_done", dma_done, 0);
`endif
    n = wr_cnt;
    src = '0; exp_idx = 0; expect_fall = 0;
    repeat (5) @(negedge clk);
    check("mrst_no_writes", wr_cnt, n);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mrst_stays_idle", {busy, wr_cnt}, {1'b0, n});
    cpu_read(16'hFF46);
    // READ_LATENCY=3 instance
    @(posedge clk); #1;
    l_reg_addr = 16'hFF46; l_reg_wdata = 8'hC1; l_reg_wr = 1'b1;
    @(posedge clk); #1;
    l_reg_wr = 1'b0; l_reg_addr = '0;
    n = 0;
    while (l_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("lat_idle_timeout", l_busy, 0);
    @(posedge clk); #1;
    check("lat_busy_cycles", l_busy_cyc, 801);
    check("lat_wr_count", l_wr_cnt, 160);
`ifdef OAM_DMA_DONE_PULSE_EN
    check("lat_done_count", l_done_cnt, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
